// File: rtl/fixture_picobello_top.sv
// Test fixture around a picobello-style DUT: stretches the DUT reset, preloads an image,
// kicks the entry point, polls the end-of-computation register and watches the UART line.
module fixture_picobello_top #(
  parameter int unsigned          AddrWidth     = 64,
  parameter int unsigned          DataWidth     = 32,
  parameter logic [AddrWidth-1:0] ScratchAddr   = 64'h0300_0008,
  parameter logic [AddrWidth-1:0] WakeAddr      = 64'h0300_0010,
  parameter int unsigned          PollInterval  = 16,
  parameter int unsigned          RstStretch    = 8,
  parameter int unsigned          UartBitCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_rst_bypass_i,
  input  logic                 start_i,
  input  logic [1:0]           boot_mode_i,
  input  logic [1:0]           preload_mode_i,
  input  logic                 snitch_preload_i,
  input  logic [AddrWidth-1:0] entry_i,
  input  logic                 pre_valid_i,
  output logic                 pre_ready_o,
  input  logic [AddrWidth-1:0] pre_addr_i,
  input  logic [DataWidth-1:0] pre_data_i,
  input  logic                 pre_last_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 dut_rst_o,
  input  logic                 uart_rx_i,
  output logic                 uart_reading_byte_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 finish_o,
  output logic [31:0]          exit_code_o
);

  typedef enum logic [3:0] {
    WAIT_RST  = 4'd0,
    IDLE      = 4'd1,
    LOAD      = 4'd2,
    KICK      = 4'd3,
    POLL_WAIT = 4'd4,
    POLL_REQ  = 4'd5,
    POLL_RSP  = 4'd6,
    DONE      = 4'd7,
    ERROR     = 4'd8
  } state_e;

  localparam logic [DataWidth-1:0] KickDefault = DataWidth'(1);
  localparam logic [15:0] StretchLast = 16'(RstStretch - 1);
  localparam logic [15:0] PollLast    = 16'(PollInterval - 1);
  localparam logic [15:0] UartLast    = 16'(10 * UartBitCycles - 1);

  state_e               state;
  state_e               next_state;
  logic [15:0]          cnt;
  logic [15:0]          cnt_next;
  logic                 latch_en;
  logic                 exit_load;
  logic                 snitch_latched;
  logic [DataWidth-1:0] entry_latched;

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [15:0]          uart_cnt;

  // Entry bits above the data width never reach the wake register.
  logic unused_entry_bits;
  assign unused_entry_bits = ^entry_i[AddrWidth-1:DataWidth];

  // Boot decode; the mode bits only steer this choice, so only the kick payload is kept.
  function automatic state_e decode_boot(input logic [1:0] boot, input logic [1:0] prel,
                                         input logic snitch);
    state_e target;
    case (boot)
      2'd0: begin
        if (prel == 2'd2 && snitch) target = ERROR;
        else                        target = LOAD;
      end
      2'd1:       target = ERROR;
      2'd2, 2'd3: target = POLL_WAIT;
      default:    target = ERROR;
    endcase
    return target;
  endfunction

  // Next-state, counter and memory-port decode.
  always_comb begin
    next_state  = state;
    cnt_next    = 16'd0;
    latch_en    = 1'b0;
    exit_load   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    pre_ready_o = 1'b0;
    case (state)
      WAIT_RST: begin
        if (clk_rst_bypass_i || cnt == StretchLast) next_state = IDLE;
        else                                        cnt_next   = cnt + 16'd1;
      end
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          latch_en   = 1'b1;
          next_state = decode_boot(boot_mode_i, preload_mode_i, snitch_preload_i);
        end else begin
          next_state = state;
        end
      end
      LOAD: begin
        mem_req_o   = pre_valid_i;
        mem_we_o    = 1'b1;
        mem_addr_o  = pre_addr_i;
        mem_wdata_o = pre_data_i;
        pre_ready_o = pre_valid_i & mem_gnt_i;
        if (pre_valid_i && mem_gnt_i && pre_last_i) next_state = KICK;
        else                                        next_state = LOAD;
      end
      KICK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = WakeAddr;
        mem_wdata_o = snitch_latched ? entry_latched : KickDefault;
        if (mem_gnt_i) next_state = POLL_WAIT;
        else           next_state = KICK;
      end
      POLL_WAIT: begin
        if (cnt == PollLast) next_state = POLL_REQ;
        else                 cnt_next   = cnt + 16'd1;
      end
      POLL_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ScratchAddr;
        if (mem_gnt_i) next_state = POLL_RSP;
        else           next_state = POLL_REQ;
      end
      POLL_RSP: begin
        if (mem_rvalid_i && mem_rdata_i[0]) begin
          exit_load  = 1'b1;
          next_state = DONE;
        end else if (mem_rvalid_i) begin
          next_state = POLL_WAIT;
        end else begin
          next_state = POLL_RSP;
        end
      end
      default: next_state = WAIT_RST;
    endcase
  end

  // State, latched start inputs and status outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= WAIT_RST;
      cnt            <= 16'd0;
      snitch_latched <= 1'b0;
      entry_latched  <= '0;
      exit_code_o    <= 32'd0;
      dut_rst_o      <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (latch_en) begin
        snitch_latched <= snitch_preload_i;
        entry_latched  <= entry_i[DataWidth-1:0];
      end
      if (exit_load) exit_code_o <= {1'b0, mem_rdata_i[31:1]};
      dut_rst_o <= (next_state == WAIT_RST);
      busy_o    <= (next_state inside {LOAD, KICK, POLL_WAIT, POLL_REQ, POLL_RSP});
      done_o    <= (next_state == DONE);
      error_o   <= (next_state == ERROR);
    end
  end

  // UART start-bit monitor: idle-high synchronizer, then a fixed one-frame window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta             <= 1'b1;
      rx_sync             <= 1'b1;
      rx_prev             <= 1'b1;
      uart_reading_byte_o <= 1'b0;
      uart_cnt            <= 16'd0;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (uart_reading_byte_o) begin
        if (uart_cnt == UartLast) begin
          uart_reading_byte_o <= 1'b0;
          uart_cnt            <= 16'd0;
        end else begin
          uart_cnt <= uart_cnt + 16'd1;
        end
      end else if (rx_prev && !rx_sync) begin
        uart_reading_byte_o <= 1'b1;
        uart_cnt            <= 16'd0;
      end else begin
        uart_cnt <= 16'd0;
      end
    end
  end

  assign finish_o = done_o & ~uart_reading_byte_o;

endmodule

// File: tb/tb_fixture_picobello_top.sv
// Self-checking bench: decode table, directed reset/poll/UART sequences and randomized
// boot flows scored against a transaction-level model of the expected memory traffic.
module tb_fixture_picobello_top;

  localparam logic [63:0] SCRATCH = 64'h0300_0008;
  localparam logic [63:0] WAKE    = 64'h0300_0010;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clk_rst_bypass_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  boot_mode_i = 2'd0;
  logic [1:0]  preload_mode_i = 2'd0;
  logic        snitch_preload_i = 1'b0;
  logic [63:0] entry_i = 64'd0;
  logic        pre_valid_i = 1'b0;
  logic        pre_ready_o;
  logic [63:0] pre_addr_i = 64'd0;
  logic [31:0] pre_data_i = 32'd0;
  logic        pre_last_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        dut_rst_o;
  logic        uart_rx_i = 1'b1;
  logic        uart_reading_byte_o, busy_o, done_o, error_o, finish_o;
  logic [31:0] exit_code_o;

  always #5 clk_i = ~clk_i;

  fixture_picobello_top dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_rst_bypass_i(clk_rst_bypass_i), .start_i(start_i),
    .boot_mode_i(boot_mode_i), .preload_mode_i(preload_mode_i),
    .snitch_preload_i(snitch_preload_i), .entry_i(entry_i),
    .pre_valid_i(pre_valid_i), .pre_ready_o(pre_ready_o), .pre_addr_i(pre_addr_i),
    .pre_data_i(pre_data_i), .pre_last_i(pre_last_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .dut_rst_o(dut_rst_o), .uart_rx_i(uart_rx_i),
    .uart_reading_byte_o(uart_reading_byte_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .finish_o(finish_o), .exit_code_o(exit_code_o)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [1:0] boot;
    logic [1:0] prel;
    logic       snitch;
    logic [2:0] expect_ebr;
  } dec_vec_t;

  xfer_t       exp_q[$];
  logic [31:0] poll_q[$];
  logic [63:0] beat_addr[4];
  logic [31:0] beat_data[4];
  logic [31:0] last_exit = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic bypass);
    int n;
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b0; pre_valid_i = 1'b0; pre_last_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; uart_rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    clk_rst_bypass_i = bypass;
    rst_i = 1'b0;
    n = 0;
    while (dut_rst_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_release", 64'(dut_rst_o), 64'd0);
    last_exit = 32'd0;
  endtask

  // One full boot: build the expected transaction list, then play memory and preload source.
  task automatic run_flow(input logic [1:0] boot, input logic [1:0] prel, input logic snitch,
                          input logic [63:0] entry, input int nbeats, input int nzero,
                          input logic [31:0] final_val, input bit directed);
    int          beat_idx, stall, rsp_delay;
    bit          ended;
    xfer_t       e;
    logic [31:0] exp_exit;
    exp_q.delete();
    poll_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      beat_addr[i] = directed ? 64'h0001_0000 + 64'(4 * i) : {$urandom, $urandom};
      beat_data[i] = directed ? 32'hA5A5_0000 + 32'(i) : $urandom;
      e.we = 1'b1; e.addr = beat_addr[i]; e.data = beat_data[i];
      exp_q.push_back(e);
    end
    if (boot == 2'd0) begin
      e.we = 1'b1; e.addr = WAKE; e.data = snitch ? entry[31:0] : 32'h1;
      exp_q.push_back(e);
    end
    for (int i = 0; i <= nzero; i++) begin
      e.we = 1'b0; e.addr = SCRATCH; e.data = 32'h0;
      exp_q.push_back(e);
      poll_q.push_back(i == nzero ? final_val : (directed ? 32'h0 : ($urandom & 32'hFFFF_FFFE)));
    end
    exp_exit = final_val >> 1;

    @(negedge clk_i);
    start_i = 1'b1; boot_mode_i = boot; preload_mode_i = prel;
    snitch_preload_i = snitch; entry_i = entry;
    pre_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    beat_idx = 0; stall = 2; rsp_delay = -1; ended = 1'b0;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (cyc == 0) check("exit_hold", 64'(exit_code_o), 64'(last_exit));
      if (done_o || error_o) begin
        ended = 1'b1;
      end else begin
        if (rsp_delay == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = (poll_q.size() > 0) ? poll_q.pop_front() : 32'h1;
          rsp_delay    = -1;
        end else begin
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = $urandom;
          if (rsp_delay > 0) rsp_delay--;
        end
        if (beat_idx < nbeats) begin
          pre_valid_i = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
          pre_addr_i  = beat_addr[beat_idx];
          pre_data_i  = beat_data[beat_idx];
          pre_last_i  = (beat_idx == nbeats - 1);
        end else begin
          pre_valid_i = 1'b0;
          pre_last_i  = 1'b0;
        end
        #1;
        if (directed) begin
          if (pre_valid_i && mem_req_o && beat_idx == 1 && stall > 0) begin
            mem_gnt_i = 1'b0;
            stall--;
          end else begin
            mem_gnt_i = 1'b1;
          end
        end else begin
          mem_gnt_i = ($urandom_range(0, 2) != 0);
        end
        #1;
        if (mem_req_o && mem_gnt_i) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_extra: got request we=%0b addr=%h, expected none", mem_we_o, mem_addr_o);
          end else begin
            e = exp_q.pop_front();
            check("xfer_we", 64'(mem_we_o), 64'(e.we));
            check("xfer_addr", mem_addr_o, e.addr);
            if (e.we) check("xfer_data", 64'(mem_wdata_o), 64'(e.data));
          end
          if (!mem_we_o) rsp_delay = directed ? 0 : $urandom_range(0, 2);
          if (pre_valid_i && pre_ready_o) beat_idx++;
        end
      end
    end
    check("run_done", 64'({error_o, done_o}), 64'd1);
    check("exit_code", 64'(exit_code_o), 64'(exp_exit));
    check("xfers_left", 64'(exp_q.size()), 64'd0);
    last_exit = exp_exit;
    mem_gnt_i = 1'b0; pre_valid_i = 1'b0; pre_last_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    dec_vec_t dec_tab[8];
    int n, low;
    dec_tab[0] = '{2'd1, 2'd0, 1'b0, 3'b100};
    dec_tab[1] = '{2'd1, 2'd1, 1'b1, 3'b100};
    dec_tab[2] = '{2'd0, 2'd2, 1'b1, 3'b100};
    dec_tab[3] = '{2'd0, 2'd2, 1'b0, 3'b010};
    dec_tab[4] = '{2'd0, 2'd1, 1'b1, 3'b010};
    dec_tab[5] = '{2'd0, 2'd3, 1'b1, 3'b010};
    dec_tab[6] = '{2'd2, 2'd2, 1'b1, 3'b010};
    dec_tab[7] = '{2'd3, 2'd0, 1'b0, 3'b010};

    // Reset values, then reset stretching with and without bypass.
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 64'({dut_rst_o, busy_o, done_o, error_o, finish_o,
                                uart_reading_byte_o, mem_req_o, mem_we_o, pre_ready_o}), 64'h100);
    check("reset_exit", 64'(exit_code_o), 64'd0);
    clk_rst_bypass_i = 1'b0;
    rst_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      check("stretch", 64'(dut_rst_o), (k < 8) ? 64'd1 : 64'd0);
    end
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    clk_rst_bypass_i = 1'b1; rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("bypass", 64'(dut_rst_o), 64'd0);

    // Boot decode table: {error, busy, req} one cycle and four cycles after start.
    for (int i = 0; i < 8; i++) begin
      do_reset(1'b1);
      @(negedge clk_i);
      start_i = 1'b1; boot_mode_i = dec_tab[i].boot; preload_mode_i = dec_tab[i].prel;
      snitch_preload_i = dec_tab[i].snitch; mem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("decode", 64'({error_o, busy_o, mem_req_o}), 64'(dec_tab[i].expect_ebr));
      repeat (3) @(posedge clk_i);
      #1;
      check("decode_hold", 64'({error_o, busy_o, mem_req_o}), 64'(dec_tab[i].expect_ebr));
    end

    // Poll-only boot: first read after the poll interval, then abort it with reset.
    do_reset(1'b1);
    @(negedge clk_i);
    start_i = 1'b1; boot_mode_i = 2'd2; preload_mode_i = 2'd0; snitch_preload_i = 1'b0;
    mem_gnt_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("poll_delay", 64'(mem_req_o), (k == 17) ? 64'd1 : 64'd0);
    end
    check("poll_rd_we", 64'(mem_we_o), 64'd0);
    check("poll_rd_addr", mem_addr_o, SCRATCH);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_req", 64'({mem_req_o, dut_rst_o}), 64'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3; clk_rst_bypass_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("stale_rvalid", 64'({busy_o, done_o, exit_code_o}), 64'd0);
    mem_rvalid_i = 1'b0;

    // Three-beat preload with a stalled second beat, two empty polls, exit code 0.
    do_reset(1'b1);
    run_flow(2'd0, 2'd1, 1'b0, 64'h0, 3, 2, 32'h0000_0001, 1'b1);

    // UART start bit while done masks finish for one frame.
    check("finish_at_done", 64'(finish_o), 64'd1);
    @(negedge clk_i); uart_rx_i = 1'b0;
    n = 0;
    while (finish_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    low = 0;
    while (!finish_o && low < 400) begin
      low++;
      if (low == 20) uart_rx_i = 1'b1;
      @(posedge clk_i); #1;
    end
    check("uart_frame_len", 64'(low), 64'd160);

    // Restart from done: odd scratch value decodes to exit code 10; snitch entry kick.
    run_flow(2'd3, 2'd0, 1'b0, 64'h0, 0, 0, 32'h0000_0015, 1'b1);
    run_flow(2'd0, 2'd3, 1'b1, 64'hDEAD_BEEF_1234_5678, 2, 0, 32'h0000_0007, 1'b1);

    // Randomized boots against the transaction model.
    for (int r = 0; r < 8; r++) begin
      logic [1:0] b, p;
      logic       s;
      int         sel;
      sel = $urandom_range(0, 2);
      b = (sel == 0) ? 2'd0 : ((sel == 1) ? 2'd2 : 2'd3);
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      if (b == 2'd0 && p == 2'd2) s = 1'b0;
      run_flow(b, p, s, {$urandom, $urandom}, (b == 2'd0) ? $urandom_range(1, 4) : 0,
               $urandom_range(0, 2), $urandom | 32'h1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fixture_picobello_top.md
FIXTURE_PICOBELLO_TOP -- requirements
Module: fixture_picobello_top

Interface
REQ-001 Parameters (name, default, meaning): AddrWidth, 64, memory address width; DataWidth, 32, memory data width; ScratchAddr, 64'h0300_0008, end-of-computation (EOC) scratch register address; WakeAddr, 64'h0300_0010, entry/wake register address; PollInterval, 16, cycles between EOC reads; RstStretch, 8, DUT reset stretch cycles; UartBitCycles, 16, cycles per UART bit.
REQ-002 Ports (name, direction, width, meaning): clk_i, in, 1, sole clock; rst_i, in, 1, reset.
REQ-003 One clock; reset is synchronous and active-high (clk_i, rst_i).
REQ-004 clk_rst_bypass_i in 1 (disable reset stretch); start_i in 1 (start pulse); boot_mode_i in 2; preload_mode_i in 2; snitch_preload_i in 1; entry_i in AddrWidth (snitch entry).
REQ-005 pre_valid_i in 1; pre_ready_o out 1; pre_addr_i in AddrWidth; pre_data_i in DataWidth; pre_last_i in 1 (image preload stream).
REQ-006 mem_req_o out 1; mem_we_o out 1; mem_addr_o out AddrWidth; mem_wdata_o out DataWidth; mem_gnt_i in 1; mem_rvalid_i in 1; mem_rdata_i in DataWidth (DUT memory port).
REQ-007 dut_rst_o out 1 (DUT reset, active-high); uart_rx_i in 1; uart_reading_byte_o out 1; busy_o, done_o, error_o, finish_o out 1; exit_code_o out 32.

Function
REQ-008 FSM states: WAIT_RST, IDLE, LOAD, KICK, POLL_WAIT, POLL_REQ, POLL_RSP, DONE, ERROR.
REQ-009 WAIT_RST: dut_rst_o=1 for RstStretch cycles after rst_i falls, then IDLE; if clk_rst_bypass_i=1, skip stretching (go to IDLE on the first cycle after reset, dut_rst_o=0).
REQ-010 IDLE: on start_i, latch boot_mode_i, preload_mode_i, snitch_preload_i, entry_i; start_i is ignored in all other states except DONE/ERROR.
REQ-011 Decode on start: boot_mode=1 -> ERROR; boot_mode=0 with preload_mode=2 and snitch_preload=1 -> ERROR; boot_mode=0 otherwise -> LOAD; boot_mode=2 or 3 -> POLL_WAIT.
REQ-012 LOAD: mem_req_o=pre_valid_i, mem_we_o=1, address/data = pre_addr_i/pre_data_i; pre_ready_o=pre_valid_i&mem_gnt_i; a beat transfers when both are high; transfer with pre_last_i=1 -> KICK.
REQ-013 KICK: one write of entry_i[DataWidth-1:0] to WakeAddr if snitch_preload latched, else 32'h1; held until mem_gnt_i, then POLL_WAIT.
REQ-014 POLL_WAIT: count PollInterval cycles, then POLL_REQ; POLL_REQ: read (mem_we_o=0) ScratchAddr until mem_gnt_i, then POLL_RSP; POLL_RSP: on mem_rvalid_i, if mem_rdata_i[0]=1 then exit_code_o <= {1'b0, mem_rdata_i[31:1]} and DONE, else POLL_WAIT.
REQ-015 mem_req_o, mem_we_o are 0 in all states other than LOAD, KICK and POLL_REQ; pre_ready_o=0 outside LOAD.
REQ-016 busy_o=1 in LOAD..POLL_RSP; done_o=1 in DONE; error_o=1 in ERROR; exit_code_o holds its value until the next done.
REQ-017 DONE/ERROR: start_i clears done_o/error_o, then re-runs the decode per REQ-011 with fresh latched inputs in the same cycle.
REQ-018 UART monitor: 2-flop synchronizer on uart_rx_i (idle high); a synchronized falling edge while not reading sets uart_reading_byte_o=1 for exactly 10*UartBitCycles cycles, then 0; edges during reading are ignored.
REQ-019 finish_o = done_o & ~uart_reading_byte_o (combinational).

Reset
REQ-020 rst_i: state WAIT_RST, dut_rst_o=1, all other outputs 0, exit_code_o=0, counters and UART monitor cleared (synchronizer reset to 1).
REQ-021 rst_i asserted mid-operation aborts any pending request immediately (mem_req_o=0 in the next cycle); in-flight rvalid after reset is ignored.

Verification
REQ-022 Reset release, bypass=0 -> dut_rst_o high 8 more cycles then low; bypass=1 -> low the next cycle.
REQ-023 boot=0, prel=1, 3 beats (last on 3rd), gnt stalled 2 cycles on beat 2 -> exactly 3 writes in order, then write of 32'h1 to 0x0300_0010.
REQ-024 Poll returns 0 twice then 32'h0000_0001 -> done_o=1, exit_code_o=0; a return of 32'h0000_0015 -> exit_code_o=10.
REQ-025 boot=1 -> error_o next cycle, no memory requests; boot=0, prel=2, snitch=1 -> error_o.
REQ-026 boot=2 -> no writes; first read issued 16 cycles after start.
REQ-027 UART start bit at done -> finish_o low for 160 cycles, then high.
